// File: rtl/vsm_acc_pkg.sv
// vsm_acc_pkg: shared op/state encodings and the select-width helper for the accumulator bank.
package vsm_acc_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_CLR, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_ASR, OP_ROL} op_e;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vsm_acc_step.sv
// vsm_acc_step: one combinational step of an accumulator op (INC/DEC/CLR or a single shift/rotate bit).
module vsm_acc_step
  import vsm_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  input  op_e              i_op,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_val,
  output logic             o_carry,
  output logic             o_carry_we
);
  logic [WIDTH:0] w_sum, w_diff;
  assign w_sum  = {1'b0, i_val} + (WIDTH+1)'(1);
  assign w_diff = {1'b0, i_val} - (WIDTH+1)'(1);
  always_comb begin
    o_val = i_val;
    o_carry = 1'b0;
    o_carry_we = i_step;
    case (i_op)
      OP_NOP: o_carry_we = 1'b0;
      OP_CLR: begin o_val = '0; o_carry_we = 1'b0; end
      OP_INC: {o_carry, o_val} = w_sum;
      OP_DEC: {o_carry, o_val} = w_diff;
      OP_SHL: {o_carry, o_val} = {i_val, 1'b0};
      OP_SHR: {o_val, o_carry} = {1'b0, i_val};
      OP_ASR: {o_val, o_carry} = {i_val[WIDTH-1], i_val};
      default: {o_carry, o_val} = {i_val, i_val[WIDTH-1]};
    endcase
    if (!i_step) o_val = i_val;
  end
endmodule

// File: rtl/vsm_accumulator_bank.sv
// vsm_accumulator_bank: NUM_ACC x WIDTH accumulators with load/clear/inc/dec and multi-cycle shifts.
// Define VSM_ACC_TRISTATE_EN to float IB when disabled; otherwise IB drives zeros.
module vsm_accumulator_bank
  import vsm_acc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4,
  parameter int SHAMT_W = 3,
  localparam int SEL_W  = sel_width(NUM_ACC)
) (
  input  logic               MainClock,
  input  logic               ClearN,
  input  logic [WIDTH-1:0]   DataIn,
  input  logic               Latch,
  input  logic [SEL_W-1:0]   Sel,
  input  logic               Start,
  input  logic [2:0]         Op,
  input  logic [SHAMT_W-1:0] ShAmt,
  input  logic               Enable,
  output logic [WIDTH-1:0]   AluA,
  output logic [WIDTH-1:0]   IB,
  output logic               Busy,
  output logic               Done,
  output logic               Zero,
  output logic               Neg,
  output logic               Carry
);
  logic [WIDTH-1:0] r_acc [NUM_ACC];
  state_e r_state, w_nstate;
  op_e r_op, w_op;
  logic [SEL_W-1:0] r_tgt, w_idx;
  logic [SHAMT_W-1:0] r_cnt;
  logic r_done, r_carry;
  logic w_busy, w_start, w_long, w_last, w_step, w_idx_ok, w_sel_ok, w_latch, w_cy, w_cy_we;
  logic [WIDTH-1:0] w_cur, w_src, w_res;

  assign w_busy   = r_state == ST_SHIFT;
  assign w_sel_ok = int'(Sel) < NUM_ACC;
  assign w_cur    = w_sel_ok ? r_acc[Sel] : '0;
  assign w_start  = !w_busy && Start && !Latch;
  assign w_long   = Op[2] && ShAmt != '0;
  assign w_last   = w_busy && r_cnt == SHAMT_W'(1);
  // the single step unit serves the selected acc when idle and the captured target while shifting
  assign w_idx    = w_busy ? r_tgt : Sel;
  assign w_idx_ok = int'(w_idx) < NUM_ACC;
  assign w_src    = w_idx_ok ? r_acc[w_idx] : '0;
  assign w_op     = w_busy ? r_op : op_e'(Op);
  assign w_step   = w_busy || (w_start && !Op[2]);
  assign w_latch  = Latch && w_sel_ok && !(w_busy && Sel == r_tgt);

  vsm_acc_step #(.WIDTH(WIDTH)) u_step (
    .i_val     (w_src),
    .i_op      (w_op),
    .i_step    (w_step),
    .o_val     (w_res),
    .o_carry   (w_cy),
    .o_carry_we(w_cy_we)
  );

  always_comb begin
    w_nstate = (w_start && w_long) ? ST_SHIFT : w_last ? ST_IDLE : r_state;
  end

  always_ff @(posedge MainClock or negedge ClearN)
    if (!ClearN) r_state <= ST_IDLE;
    else r_state <= w_nstate;

  always_ff @(posedge MainClock or negedge ClearN)
    if (!ClearN) begin
      r_acc   <= '{default: '0};
      r_done  <= 1'b0;
      r_carry <= 1'b0;
      r_tgt   <= '0;
      r_op    <= OP_NOP;
      r_cnt   <= '0;
    end else begin
      r_done <= (w_start && !w_long) || w_last;
      if (w_start) begin
        r_tgt <= Sel;
        r_op  <= op_e'(Op);
        r_cnt <= ShAmt;
      end else if (w_busy) r_cnt <= r_cnt - SHAMT_W'(1);
      if (w_step && w_idx_ok) r_acc[w_idx] <= w_res;
      if (w_step && w_cy_we) r_carry <= w_cy;
      if (w_latch) r_acc[Sel] <= DataIn;
    end

  assign AluA  = w_cur;
  assign Busy  = w_busy;
  assign Done  = r_done;
  assign Zero  = w_cur == '0;
  assign Neg   = w_cur[WIDTH-1];
  assign Carry = r_carry;
`ifdef VSM_ACC_TRISTATE_EN
  assign IB = Enable ? w_cur : 'z;
`else
  assign IB = Enable ? w_cur : '0;
`endif
endmodule

// File: tb/tb_vsm_accumulator_bank.sv
// tb_vsm_accumulator_bank: table vectors, corner sequences and a random run against an arithmetic model.
module tb_vsm_accumulator_bank;
  logic MainClock = 1'b0, ClearN = 1'b1, Latch = 1'b0, Start = 1'b0, Enable = 1'b0;
  logic [7:0] DataIn = '0;
  logic [1:0] Sel = '0;
  logic [2:0] Op = '0, ShAmt = '0;
  logic [7:0] AluA, IB;
  logic Busy, Done, Zero, Neg, Carry;
  int checks = 0, errors = 0;
  int m_acc [4];
  bit m_c;

  always #5 MainClock = ~MainClock;

  vsm_accumulator_bank dut (
    .MainClock(MainClock), .ClearN(ClearN), .DataIn(DataIn), .Latch(Latch), .Sel(Sel),
    .Start(Start), .Op(Op), .ShAmt(ShAmt), .Enable(Enable), .AluA(AluA), .IB(IB),
    .Busy(Busy), .Done(Done), .Zero(Zero), .Neg(Neg), .Carry(Carry)
  );

  typedef struct {
    int op;
    int sh;
    logic [7:0] init;
    logic [7:0] res;
    logic c;
    bit chk_c;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MainClock);
    #1;
  endtask

  task automatic do_reset();
    ClearN = 1'b0;
    #2;
    ClearN = 1'b1;
  endtask

  task automatic latch_acc(input int s, input int d);
    Sel = s[1:0];
    DataIn = d[7:0];
    Latch = 1'b1;
    tick();
    Latch = 1'b0;
  endtask

  task automatic run_op(input int s, input int op, input int n, output int nb, output int nd);
    Sel = s[1:0];
    Op = op[2:0];
    ShAmt = n[2:0];
    Start = 1'b1;
    tick();
    Start = 1'b0;
    nb = 0;
    nd = 0;
    for (int k = 0; k <= n + 2; k++) begin
      nb += int'(Busy);
      nd += int'(Done);
      tick();
    end
  endtask

  function automatic void model_op(input int s, input int op, input int n);
    int v = m_acc[s];
    if (op == 1) v = 0;
    else if (op == 2) begin
      v = v + 1;
      m_c = v > 255;
      v = v % 256;
    end else if (op == 3) begin
      m_c = v == 0;
      v = (v + 255) % 256;
    end else if (op >= 4) begin
      for (int i = 0; i < n; i++) begin
        if (op == 4) begin m_c = v >= 128; v = (v * 2) % 256; end
        else if (op == 5) begin m_c = v % 2 == 1; v = v / 2; end
        else if (op == 6) begin m_c = v % 2 == 1; v = v / 2 + (v >= 128 ? 128 : 0); end
        else begin m_c = v >= 128; v = (v * 2) % 256 + (v >= 128 ? 1 : 0); end
      end
    end
    m_acc[s] = v;
  endfunction

  initial begin
    int nb, nd, op, n, s, d;
    tbl[0]  = '{2, 0, 8'hFF, 8'h00, 1'b1, 1'b1};
    tbl[1]  = '{3, 0, 8'h00, 8'hFF, 1'b1, 1'b1};
    tbl[2]  = '{2, 0, 8'h3F, 8'h40, 1'b0, 1'b1};
    tbl[3]  = '{3, 0, 8'h80, 8'h7F, 1'b0, 1'b1};
    tbl[4]  = '{4, 3, 8'h81, 8'h08, 1'b0, 1'b1};
    tbl[5]  = '{6, 1, 8'h81, 8'hC0, 1'b1, 1'b1};
    tbl[6]  = '{7, 1, 8'h81, 8'h03, 1'b1, 1'b1};
    tbl[7]  = '{5, 7, 8'h81, 8'h01, 1'b0, 1'b1};
    tbl[8]  = '{7, 7, 8'h81, 8'hC0, 1'b0, 1'b1};
    tbl[9]  = '{6, 7, 8'h80, 8'hFF, 1'b0, 1'b1};
    tbl[10] = '{1, 0, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{4, 0, 8'h81, 8'h81, 1'b0, 1'b0};

    #1;
    do_reset();
    tick();
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_done", 32'(Done), 0);
    chk("reset_carry", 32'(Carry), 0);
    for (int i = 0; i < 4; i++) begin
      Sel = 2'(i);
      #1;
      chk("reset_acc", 32'(AluA), 0);
    end

    latch_acc(2, 8'hA5);
    Enable = 1'b1;
    #1;
    chk("load_alua", 32'(AluA), 32'hA5);
    chk("load_ib", 32'(IB), 32'hA5);
    chk("load_zero", 32'(Zero), 0);
    chk("load_neg", 32'(Neg), 1);
    chk("load_carry", 32'(Carry), 0);
    Enable = 1'b0;
    #1;
`ifdef VSM_ACC_TRISTATE_EN
    chk("ib_disabled_float", 32'($isunknown(IB) || IB == 8'h00), 1);
`else
    chk("ib_disabled_zero", 32'(IB), 0);
`endif
    chk("alua_when_disabled", 32'(AluA), 32'hA5);

    foreach (tbl[i]) begin
      latch_acc(1, int'(tbl[i].init));
      run_op(1, tbl[i].op, tbl[i].sh, nb, nd);
      chk($sformatf("vec%0d_val", i), 32'(AluA), 32'(tbl[i].res));
      chk($sformatf("vec%0d_zero", i), 32'(Zero), 32'(tbl[i].res == 0));
      chk($sformatf("vec%0d_neg", i), 32'(Neg), 32'(tbl[i].res[7]));
      if (tbl[i].chk_c) chk($sformatf("vec%0d_carry", i), 32'(Carry), 32'(tbl[i].c));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(tbl[i].op >= 4 ? tbl[i].sh : 0));
      chk($sformatf("vec%0d_done_pulses", i), 32'(nd), 1);
    end

    latch_acc(1, 8'h81);
    Sel = 2'd1; Op = 3'd4; ShAmt = 3'd3; Start = 1'b1;
    tick();
    Op = 3'd2;
    nb = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) Start = 1'b0;
      nb += int'(Busy);
      nd += int'(Done);
      tick();
    end
    chk("busy_start_val", 32'(AluA), 32'h08);
    chk("busy_start_carry", 32'(Carry), 0);
    chk("busy_start_cycles", 32'(nb), 3);
    chk("busy_start_dones", 32'(nd), 1);

    latch_acc(3, 8'h11);
    latch_acc(0, 8'h80);
    Sel = 2'd0; Op = 3'd5; ShAmt = 3'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("shr_busy", 32'(Busy), 1);
    DataIn = 8'h55; Latch = 1'b1;
    tick();
    chk("latch_tgt_ignored", 32'(AluA), 32'h40);
    Sel = 2'd3; DataIn = 8'h3C;
    tick();
    Latch = 1'b0;
    #1;
    chk("latch_other_ok", 32'(AluA), 32'h3C);
    Sel = 2'd0;
    #1;
    chk("shr_progress", 32'(AluA), 32'h20);
    do_reset();
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_done", 32'(Done), 0);
    for (int i = 0; i < 4; i++) begin
      Sel = 2'(i);
      #1;
      chk("abort_acc", 32'(AluA), 0);
    end
    nb = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      nb += int'(Busy);
      nd += int'(Done);
    end
    chk("abort_no_busy", 32'(nb), 0);
    chk("abort_no_done", 32'(nd), 0);

    do_reset();
    tick();
    m_acc = '{0, 0, 0, 0};
    m_c = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        s = int'($urandom_range(0, 3));
        d = int'($urandom_range(0, 255));
        latch_acc(s, d);
        m_acc[s] = d;
      end
      s = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 7));
      run_op(s, op, n, nb, nd);
      model_op(s, op, n);
      chk($sformatf("rnd%0d_carry", it), 32'(Carry), 32'(m_c));
      chk($sformatf("rnd%0d_busy_cycles", it), 32'(nb), 32'(op >= 4 ? n : 0));
      chk($sformatf("rnd%0d_done_pulses", it), 32'(nd), 1);
      for (int i = 0; i < 4; i++) begin
        Sel = 2'(i);
        #1;
        chk($sformatf("rnd%0d_acc%0d", it, i), 32'(AluA), 32'(m_acc[i]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vsm_accumulator_bank.md
Name: vsm_accumulator_bank

Overview:
- Parametrised successor to the 4-bit VSM accumulator register.
- Holds NUM_ACC accumulators of WIDTH bits and supports parallel load, clear, increment/decrement and multi-cycle shift/rotate, with Busy/Done handshake and status flags.
- The selected accumulator feeds the ALU A-operand directly; it drives the internal bus IB only when Enable is high.

Parameters:
- WIDTH, 8, accumulator and data width in bits (>=2).
- NUM_ACC, 4, number of accumulators (>=1); SEL_W = max(1, clog2(NUM_ACC)).
- SHAMT_W, 3, shift-amount width; shifts of 0..2^SHAMT_W-1 bits.

Ports:
- MainClock  in  1  system clock; all state updates on the rising edge.
- ClearN  in  1  asynchronous active-low reset.
- DataIn  in  WIDTH  load data from ALU result / data bus.
- Latch  in  1  load DataIn into acc[Sel].
- Sel  in  SEL_W  selects the accumulator for Latch, Start, AluA, IB and flags.
- Start  in  1  begin operation Op on acc[Sel].
- Op  in  3  operation code, see Behaviour.
- ShAmt  in  SHAMT_W  shift/rotate count.
- Enable  in  1  drive IB with acc[Sel].
- AluA  out  WIDTH  acc[Sel], combinational.
- IB  out  WIDTH  bus output.
- Busy  out  1  a multi-cycle operation is in progress.
- Done  out  1  one-cycle pulse when an operation completes.
- Zero  out  1  acc[Sel] == 0, combinational.
- Neg  out  1  acc[Sel][WIDTH-1], combinational.
- Carry  out  1  registered carry/borrow/shifted-out bit.

Behaviour:
- Reset (ClearN low, asynchronous): all accumulators 0, Busy 0, Done 0, Carry 0, controller IDLE.
- Op encoding:
  - 0 NOP; 1 CLR; 2 INC; 3 DEC.
  - 4 SHL (logical); 5 SHR (logical); 6 ASR (arithmetic right); 7 ROL (rotate left).
- FSM states IDLE and SHIFT.
- IDLE, Start=1, Latch=0:
  - Sel is captured into TgtSel.
  - Ops 0-3 complete on that edge. INC: Carry = carry-out. DEC: Carry = borrow. CLR/NOP leave Carry unchanged. Done = 1 for the following cycle.
  - Ops 4-7 with ShAmt=n>0: Busy goes 1 and the counter loads n; go to SHIFT.
  - Ops 4-7 with ShAmt=0: no change, Carry unchanged, Done pulses, stay IDLE.
- SHIFT: one bit per edge on acc[TgtSel].
  - Carry = the bit shifted out (for ROL, the bit rotated out).
  - The counter decrements. On the edge where it reaches 0: Busy goes 0, Done pulses one cycle, return to IDLE.
  - An n-bit shift occupies Busy for exactly n cycles.
- Start while Busy is ignored.
- Latch:
  - acc[Sel] <= DataIn on the edge; Carry unchanged.
  - Latch and Start in the same IDLE cycle: Latch wins and Start is dropped (no Done).
  - Latch while Busy with Sel == TgtSel is ignored; with Sel != TgtSel it is accepted.
- Wrap-around: INC of all-ones gives 0 with Carry=1. DEC of 0 gives all-ones with Carry=1.
- Reset asserted mid-shift aborts immediately: state IDLE, Busy 0, no Done.
- IB: acc[Sel] when Enable=1; disabled value per Optional Feature.

Optional Feature:
- Macro VSM_ACC_TRISTATE_EN.
- Defined: IB is 'z when Enable=0, for the shared internal bus (as in the 4-bit block).
- Undefined: IB drives all-zeros when Enable=0, for OR-combined multiplexed buses on FPGA targets.
- Other behaviour is identical.

Decomposition:
- Package vsm_acc_pkg:
  - op enum (OP_NOP..OP_ROL, 3 bits);
  - FSM state enum;
  - SEL_W/clog2 helper function.
- Sub-module vsm_acc_step (combinational, WIDTH-parametrised): given value, op and one-step request, returns next value and carry. Used for INC/DEC and for each single shift step.
- The top module holds the register array, FSM, counter, flags and bus driver.

Test Plan:
- Reset then Latch DataIn=8'hA5 Sel=2; set Sel=2, Enable=1 -> AluA=IB=8'hA5, Zero=0, Neg=1, Carry=0.
- acc0=8'hFF, Start Op=INC -> next edge acc0=8'h00, Carry=1, Zero=1, Done high exactly 1 cycle; repeat with DEC on 0 -> 8'hFF, Carry=1.
- acc1=8'h81, Start Op=SHL ShAmt=3 -> Busy high exactly 3 cycles, acc1=8'h08, Carry=0 (last bit out), single Done pulse; Start during Busy ignored.
- acc1=8'h81, ASR ShAmt=1 -> 8'hC0, Carry=1; ROL ShAmt=1 on 8'h81 -> 8'h03, Carry=1; Op=SHL ShAmt=0 -> unchanged, Done pulses, Busy never high.
- During a 5-bit SHR on acc0: Latch Sel=0 ignored, Latch Sel=3 DataIn=8'h3C accepted; ClearN pulsed low mid-shift -> all accs 0, Busy 0, no Done.
- Enable=0 -> IB = 'z with VSM_ACC_TRISTATE_EN, IB = 8'h00 without; AluA unaffected in both.
